// File: rtl/umi_ram_pkg.sv
// Shared UMI command field positions, opcodes and the byte-lane mask helper for umi_ram.
// The optional out-of-range check is enabled with the macro UMI_RAM_OOB_CHECK_EN.
package umi_ram_pkg;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 7;
  localparam int SIZE_LSB   = 8;
  localparam int SIZE_MSB   = 11;

  localparam logic [7:0] OPC_READ         = 8'h08;
  localparam logic [7:0] OPC_WRITE_POSTED = 8'h01;
  localparam logic [7:0] OPC_READ_RESP    = 8'h02;
  localparam logic [7:0] OPC_ERROR        = 8'h0F;

  // Widest supported word in bytes; callers slice the low DW/8 lanes.
  localparam int MAX_BYTES = 128;

  // Lanes offset..offset+2^size-1 set; anything past the word end is dropped by the caller's slice.
  function automatic logic [MAX_BYTES-1:0] be_mask(input logic [3:0] size, input logic [6:0] offset);
    logic [MAX_BYTES-1:0] mask;
    logic [16:0]          lo;
    logic [16:0]          hi;
    lo   = {10'd0, offset};
    hi   = lo + (17'd1 << size);
    mask = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if ((17'(i) >= lo) && (17'(i) < hi)) begin
        mask[i] = 1'b1;
      end else begin
        mask[i] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/umi_ram_mem.sv
// DEPTH x DW storage with byte-enabled synchronous write and combinational read.
// Contents are deliberately not reset.
module umi_ram_mem #(
  parameter int DW    = 256,
  parameter int DEPTH = 512,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IW-1:0]   addr,
  input  logic [DW/8-1:0] be,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem_r [DEPTH];

  // Byte-lane write on the rising edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DW / 8; i++) begin
      if (we && be[i]) begin
        mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/umi_ram.sv
// UMI device-side RAM: posted writes into memory, reads answered through a single response register.
// Define UMI_RAM_OOB_CHECK_EN to reject word indices >= DEPTH instead of wrapping them.
module umi_ram
  import umi_ram_pkg::*;
#(
  parameter int DW    = 256,
  parameter int AW    = 64,
  parameter int CW    = 32,
  parameter int DEPTH = 512
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          udev_req_valid,
  output logic          udev_req_ready,
  input  logic [CW-1:0] udev_req_cmd,
  input  logic [AW-1:0] udev_req_dstaddr,
  input  logic [AW-1:0] udev_req_srcaddr,
  input  logic [DW-1:0] udev_req_data,
  output logic          udev_resp_valid,
  input  logic          udev_resp_ready,
  output logic [CW-1:0] udev_resp_cmd,
  output logic [AW-1:0] udev_resp_dstaddr,
  output logic [AW-1:0] udev_resp_srcaddr,
  output logic [DW-1:0] udev_resp_data
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  logic                 req_fire_s;
  logic                 is_read_s;
  logic                 is_write_s;
  logic                 oob_s;
  logic [7:0]           opcode_s;
  logic [3:0]           size_s;
  logic [OW-1:0]        offset_s;
  logic [IW-1:0]        index_s;
  logic [MAX_BYTES-1:0] wmask_full_s;
  logic [MAX_BYTES-1:0] rmask_full_s;
  logic [NB-1:0]        wbe_s;
  logic [NB-1:0]        rbe_s;
  logic [DW-1:0]        wdata_s;
  logic [DW-1:0]        mem_rdata_s;
  logic [DW-1:0]        rdata_s;
  logic [DW-1:0]        rmask_s;
  logic [CW-1:0]        resp_cmd_s;
  logic                 unused_s;

  assign udev_req_ready = !udev_resp_valid || udev_resp_ready;
  assign req_fire_s     = udev_req_valid && udev_req_ready;
  assign opcode_s       = udev_req_cmd[OPCODE_MSB:OPCODE_LSB];
  assign size_s         = udev_req_cmd[SIZE_MSB:SIZE_LSB];
  assign offset_s       = udev_req_dstaddr[OW-1:0];
  assign index_s        = udev_req_dstaddr[OW +: IW];

`ifdef UMI_RAM_OOB_CHECK_EN
  assign oob_s = |(udev_req_dstaddr >> (OW + IW));
`else
  assign oob_s = 1'b0;
`endif

  assign unused_s = ^{udev_req_cmd, udev_req_dstaddr, wmask_full_s, rmask_full_s};

  // Opcode decode; unknown opcodes are accepted and dropped.
  always_comb begin
    is_read_s  = 1'b0;
    is_write_s = 1'b0;
    case (opcode_s)
      OPC_READ:         is_read_s  = 1'b1;
      OPC_WRITE_POSTED: is_write_s = 1'b1;
      default: begin
        is_read_s  = 1'b0;
        is_write_s = 1'b0;
      end
    endcase
  end

  // Writes are aligned up to the offset; reads are aligned down to byte 0.
  assign wmask_full_s = be_mask(size_s, 7'(offset_s));
  assign rmask_full_s = be_mask(size_s, 7'd0);
  assign wbe_s        = wmask_full_s[NB-1:0];
  assign rbe_s        = rmask_full_s[NB-1:0];
  assign wdata_s      = udev_req_data << {offset_s, 3'b000};
  assign rdata_s      = mem_rdata_s >> {offset_s, 3'b000};

  // Expand the read byte mask to bit lanes.
  always_comb begin
    rmask_s = '0;
    for (int i = 0; i < NB; i++) begin
      rmask_s[i*8 +: 8] = {8{rbe_s[i]}};
    end
  end

  // Response command: only opcode and SIZE are populated.
  always_comb begin
    resp_cmd_s                      = '0;
    resp_cmd_s[SIZE_MSB:SIZE_LSB]   = size_s;
    if (oob_s) begin
      resp_cmd_s[OPCODE_MSB:OPCODE_LSB] = OPC_ERROR;
    end else begin
      resp_cmd_s[OPCODE_MSB:OPCODE_LSB] = OPC_READ_RESP;
    end
  end

  umi_ram_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk   (clk),
    .we    (req_fire_s && is_write_s && !oob_s),
    .addr  (index_s),
    .be    (wbe_s),
    .wdata (wdata_s),
    .rdata (mem_rdata_s)
  );

  // Single-entry response register; a new read replaces a response being accepted this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      udev_resp_valid   <= 1'b0;
      udev_resp_cmd     <= '0;
      udev_resp_dstaddr <= '0;
      udev_resp_srcaddr <= '0;
      udev_resp_data    <= '0;
    end else if (req_fire_s && is_read_s) begin
      udev_resp_valid   <= 1'b1;
      udev_resp_cmd     <= resp_cmd_s;
      udev_resp_dstaddr <= udev_req_srcaddr;
      udev_resp_srcaddr <= udev_req_dstaddr;
      udev_resp_data    <= oob_s ? '0 : (rdata_s & rmask_s);
    end else if (udev_resp_ready) begin
      udev_resp_valid   <= 1'b0;
    end else begin
      udev_resp_valid   <= udev_resp_valid;
    end
  end

endmodule

// File: tb/tb_umi_ram.sv
// Self-checking bench for umi_ram: directed steps plus random traffic against a byte-array memory model.
module tb_umi_ram;

  localparam int DW    = 256;
  localparam int AW    = 64;
  localparam int CW    = 32;
  localparam int DEPTH = 512;
  localparam int NB    = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          udev_req_valid;
  logic          udev_req_ready;
  logic [CW-1:0] udev_req_cmd;
  logic [AW-1:0] udev_req_dstaddr;
  logic [AW-1:0] udev_req_srcaddr;
  logic [DW-1:0] udev_req_data;
  logic          udev_resp_valid;
  logic          udev_resp_ready;
  logic [CW-1:0] udev_resp_cmd;
  logic [AW-1:0] udev_resp_dstaddr;
  logic [AW-1:0] udev_resp_srcaddr;
  logic [DW-1:0] udev_resp_data;

  int errors = 0;
  int checks = 0;
  logic [7:0] mem_m [DEPTH*NB];

  umi_ram #(.DW(DW), .AW(AW), .CW(CW), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .udev_req_valid    (udev_req_valid),
    .udev_req_ready    (udev_req_ready),
    .udev_req_cmd      (udev_req_cmd),
    .udev_req_dstaddr  (udev_req_dstaddr),
    .udev_req_srcaddr  (udev_req_srcaddr),
    .udev_req_data     (udev_req_data),
    .udev_resp_valid   (udev_resp_valid),
    .udev_resp_ready   (udev_resp_ready),
    .udev_resp_cmd     (udev_resp_cmd),
    .udev_resp_dstaddr (udev_resp_dstaddr),
    .udev_resp_srcaddr (udev_resp_srcaddr),
    .udev_resp_data    (udev_resp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Reference model: a flat byte array, one word = NB consecutive bytes.
  function automatic bit in_range(input logic [AW-1:0] a);
`ifdef UMI_RAM_OOB_CHECK_EN
    return (a / NB) < DEPTH;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int n_bytes(input logic [3:0] size, input int off);
    int n;
    n = 1 << size;
    if (off + n > NB) n = NB - off;
    return n;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [3:0] size, input logic [DW-1:0] d);
    int base, off;
    if (!in_range(a)) return;
    base = int'((a / NB) % DEPTH) * NB;
    off  = int'(a % NB);
    for (int i = 0; i < n_bytes(size, off); i++) mem_m[base + off + i] = d[8*i +: 8];
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input logic [3:0] size);
    logic [DW-1:0] r;
    int base, off;
    r = '0;
    if (!in_range(a)) return r;
    base = int'((a / NB) % DEPTH) * NB;
    off  = int'(a % NB);
    for (int i = 0; i < n_bytes(size, off); i++) r[8*i +: 8] = mem_m[base + off + i];
    return r;
  endfunction

  function automatic logic [CW-1:0] model_cmd(input logic [AW-1:0] a, input logic [3:0] size);
    return {20'h0, size, (in_range(a) ? 8'h02 : 8'h0F)};
  endfunction

  // Drive one request and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] opc, input logic [3:0] size, input logic [AW-1:0] dst,
                      input logic [AW-1:0] src, input logic [DW-1:0] data);
    int n;
    udev_req_valid   = 1'b1;
    udev_req_cmd     = {20'h0, size, opc};
    udev_req_dstaddr = dst;
    udev_req_srcaddr = src;
    udev_req_data    = data;
    n = 0;
    @(negedge clk);
    while (!udev_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", DW'(udev_req_ready), DW'(1'b1));
    @(posedge clk);
    #1;
    udev_req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] size, input logic [AW-1:0] dst, input logic [DW-1:0] d);
    model_write(dst, size, d);
    send(8'h01, size, dst, 64'h0, d);
  endtask

  task automatic check_resp(input string tag, input logic [AW-1:0] dst, input logic [AW-1:0] src,
                            input logic [3:0] size, input logic [DW-1:0] exp_d);
    chk({tag, "_valid"}, DW'(udev_resp_valid), DW'(1'b1));
    chk({tag, "_cmd"}, DW'(udev_resp_cmd), DW'(model_cmd(dst, size)));
    chk({tag, "_dst"}, DW'(udev_resp_dstaddr), DW'(src));
    chk({tag, "_src"}, DW'(udev_resp_srcaddr), DW'(dst));
    chk({tag, "_data"}, udev_resp_data, exp_d);
  endtask

  task automatic do_read(input string tag, input logic [3:0] size, input logic [AW-1:0] dst,
                         input logic [AW-1:0] src);
    logic [DW-1:0] exp_d;
    exp_d = model_read(dst, size);
    send(8'h08, size, dst, src, rand_data());
    @(negedge clk);
    check_resp(tag, dst, src, size, exp_d);
  endtask

  initial begin
    logic [DW-1:0]  d;
    logic [DW-1:0]  e1;
    logic [AW-1:0]  ba [8];
    logic [DW-1:0]  be_d [8];
    logic [AW-1:0]  a;
    logic [3:0]     sz;

    reset            = 1'b1;
    udev_req_valid   = 1'b0;
    udev_req_cmd     = '0;
    udev_req_dstaddr = '0;
    udev_req_srcaddr = '0;
    udev_req_data    = '0;
    udev_resp_ready  = 1'b1;
    #1;
    chk("rst_valid", DW'(udev_resp_valid), DW'(1'b0));
    chk("rst_cmd", DW'(udev_resp_cmd), DW'(0));
    chk("rst_dst", DW'(udev_resp_dstaddr), DW'(0));
    chk("rst_src", DW'(udev_resp_srcaddr), DW'(0));
    chk("rst_data", udev_resp_data, DW'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill memory so every later read is defined.
    for (int w = 0; w < DEPTH; w++) do_write(4'd5, 64'(w * NB), rand_data());

    // Full-word write of 0x00..0x1F then read back.
    for (int i = 0; i < NB; i++) d[8*i +: 8] = 8'(i);
    do_write(4'd5, 64'h0, d);
    do_read("full_word", 4'd5, 64'h0, 64'h1234);
    chk("full_word_lit", udev_resp_data, d);

    // 4-byte write at an offset; rest of the word untouched.
    do_write(4'd2, 64'h24, {224'h0, 32'hDEADBEEF});
    do_read("word4", 4'd2, 64'h24, 64'h55);
    chk("word4_lit", udev_resp_data, {224'h0, 32'hDEADBEEF});
    do_read("word4_whole", 4'd5, 64'h20, 64'h56);

    // Single byte write, halfword read.
    do_write(4'd0, 64'h41, {248'h0, 8'hAA});
    do_read("byte", 4'd1, 64'h40, 64'h77);

    // Accesses truncated at the word end.
    do_write(4'd5, 64'h7C, rand_data());
    do_read("trunc_whole", 4'd5, 64'h60, 64'h88);
    do_read("trunc_read", 4'd3, 64'h7A, 64'h89);

    // Aliasing of word indices >= DEPTH.
    do_write(4'd3, 64'(DEPTH * NB) + 64'h48, rand_data());
    do_read("alias_low", 4'd4, 64'h40, 64'h99);
    do_read("alias_high", 4'd4, 64'(3 * DEPTH * NB) + 64'h40, 64'h9A);

    // Stalled response sink.
    @(posedge clk);
    #1;
    udev_resp_ready = 1'b0;
    e1 = model_read(64'h0, 4'd5);
    do_read("stall_first", 4'd5, 64'h0, 64'hAAAA);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ready", DW'(udev_req_ready), DW'(1'b0));
      check_resp("stall_hold", 64'h0, 64'hAAAA, 4'd5, e1);
    end
    udev_req_valid   = 1'b1;
    udev_req_cmd     = {20'h0, 4'd2, 8'h08};
    udev_req_dstaddr = 64'h24;
    udev_req_srcaddr = 64'hBBBB;
    @(negedge clk);
    chk("stall_blocked", DW'(udev_req_ready), DW'(1'b0));
    #2;
    udev_resp_ready = 1'b1;
    #1;
    chk("stall_release", DW'(udev_req_ready), DW'(1'b1));
    @(posedge clk);
    #1;
    udev_req_valid = 1'b0;
    @(negedge clk);
    check_resp("stall_second", 64'h24, 64'hBBBB, 4'd2, model_read(64'h24, 4'd2));

    // Eight back-to-back reads at full rate.
    @(posedge clk);
    #1;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        ba[k]   = 64'($urandom_range(0, 16 * NB - 1));
        be_d[k] = model_read(ba[k], 4'd5);
        udev_req_valid   = 1'b1;
        udev_req_cmd     = {20'h0, 4'd5, 8'h08};
        udev_req_dstaddr = ba[k];
        udev_req_srcaddr = 64'(16'hC000 + k);
      end else begin
        udev_req_valid = 1'b0;
      end
      @(negedge clk);
      if (k < 8) chk("b2b_ready", DW'(udev_req_ready), DW'(1'b1));
      if (k > 0) check_resp("b2b", ba[k-1], 64'(16'hC000 + k - 1), 4'd5, be_d[k-1]);
      else chk("b2b_idle", DW'(udev_resp_valid), DW'(1'b0));
      @(posedge clk);
      #1;
    end

    // Write immediately followed by a read of the same address.
    do_write(4'd5, 64'h100, rand_data());
    do_read("raw", 4'd5, 64'h100, 64'hD0);

    // Random traffic against the model.
    for (int k = 0; k < 120; k++) begin
      sz = 4'($urandom_range(0, 5));
      a  = 64'($urandom_range(0, 4 * NB - 1));
      if ($urandom_range(0, 3) == 0) a = a + 64'(DEPTH * NB) * 64'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 0) do_write(sz, a, rand_data());
      else do_read("rand", sz, a, 64'($urandom));
    end

    // Reset while a response is pending drops it at once.
    @(posedge clk);
    #1;
    udev_resp_ready = 1'b0;
    send(8'h08, 4'd5, 64'h0, 64'hEEEE, rand_data());
    @(negedge clk);
    chk("prerst_valid", DW'(udev_resp_valid), DW'(1'b1));
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_valid", DW'(udev_resp_valid), DW'(1'b0));
    chk("midrst_data", udev_resp_data, DW'(0));
    chk("midrst_cmd", DW'(udev_resp_cmd), DW'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    udev_resp_ready = 1'b1;

    // Unknown opcode and posted write produce no response.
    send(8'h55, 4'd5, 64'h0, 64'h1, rand_data());
    @(negedge clk);
    chk("unk_noresp", DW'(udev_resp_valid), DW'(1'b0));
    @(negedge clk);
    chk("unk_noresp2", DW'(udev_resp_valid), DW'(1'b0));
    do_write(4'd5, 64'h0, d);
    @(negedge clk);
    chk("write_noresp", DW'(udev_resp_valid), DW'(1'b0));
    do_read("post_rst", 4'd5, 64'h0, 64'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/umi_ram.md
Name: umi_ram

Overview:
- UMI-attached device-side RAM.
- Accepts UMI requests on the udev_req channel.
  - Writes store data into an internal memory array.
  - Reads return data on the udev_resp channel.
- Sits behind a UMI host or simulation bridge as a simple memory-mapped endpoint.

Parameters:
DW, 256, data bus width in bits; multiple of 8, power of two.
AW, 64, address width in bits.
CW, 32, command width in bits.
DEPTH, 512, number of DW-bit memory words; power of two.

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous active-high reset
udev_req_valid  input  1  request valid
udev_req_ready  output  1  request ready
udev_req_cmd  input  CW  request command
udev_req_dstaddr  input  AW  byte address to access
udev_req_srcaddr  input  AW  requester return address
udev_req_data  input  DW  write data, byte 0 in bits [7:0]
udev_resp_valid  output  1  response valid
udev_resp_ready  input  1  response ready
udev_resp_cmd  output  CW  response command
udev_resp_dstaddr  output  AW  response destination (= request srcaddr)
udev_resp_srcaddr  output  AW  response source (= request dstaddr)
udev_resp_data  output  DW  read data

Behaviour:
- Handshakes:
  - A transfer occurs on any rising edge where valid and ready are both high.
  - A valid signal, once raised, holds its payload stable until accepted.
- Command fields:
  - cmd[7:0] is the opcode: 0x08 READ, 0x01 WRITE_POSTED, 0x02 READ_RESP (response only).
  - cmd[11:8] is SIZE; transfer is 2^SIZE bytes, legal 0..log2(DW/8).
  - All other cmd bits are ignored on input and driven 0 on output.
- Addressing:
  - Word index = dstaddr / (DW/8), taken modulo DEPTH.
  - Byte offset = dstaddr mod (DW/8).
  - Accesses never straddle a word boundary: offset + 2^SIZE beyond DW/8 is truncated at the word end.
- WRITE_POSTED:
  - On acceptance, write bytes offset..offset+2^SIZE-1 of the word from udev_req_data bytes 0..2^SIZE-1.
  - Other bytes are untouched.
  - No response is generated.
- READ:
  - On acceptance, register a response that is visible the next cycle (1-cycle latency).
  - resp_cmd = opcode 0x02 with the same SIZE.
  - resp_dstaddr = req_srcaddr; resp_srcaddr = req_dstaddr.
  - resp_data bytes 0..2^SIZE-1 = memory bytes starting at the offset; upper bytes 0.
- Other opcodes: accepted and silently dropped.
- Single-entry response register:
  - udev_req_ready = !udev_resp_valid || udev_resp_ready, combinational.
  - This permits back-to-back reads at full rate when the response sink is always ready.
  - Response valid and response accept in the same cycle: the new response replaces the old one with no bubble.
- Write followed by a read to the same address in the next cycle returns the new data (no read-during-write hazard visible).
- Reset:
  - udev_resp_valid=0; udev_resp_cmd/dstaddr/srcaddr/data=0.
  - Memory contents are not reset (undefined; benches write before reading).
  - Reset mid-transaction drops any pending response.

Optional Feature:
- Macro UMI_RAM_OOB_CHECK_EN.
- Defined:
  - A request whose word index (dstaddr / (DW/8)) is >= DEPTH is out of range; it is not aliased.
  - Out-of-range writes are discarded.
  - Out-of-range reads return a response with opcode 0x0F (ERROR), data 0, addresses swapped as normal.
- Undefined: addresses wrap modulo DEPTH and no error opcode exists.

Decomposition:
- Package umi_ram_pkg:
  - Opcode constants (READ, WRITE_POSTED, READ_RESP, ERROR).
  - cmd field positions (OPCODE_LSB/MSB, SIZE_LSB/MSB).
  - Function that builds the byte-enable mask from SIZE and offset.
- One natural sub-module, umi_ram_mem: DEPTH x DW array with byte-enabled synchronous write and combinational read port.

Test Plan:
- Posted write 32 bytes (SIZE=5) of 0x00..0x1F to addr 0x0, then READ SIZE=5 from 0x0 with srcaddr 0x1234 -> one response: opcode 0x02, SIZE=5, dstaddr 0x1234, srcaddr 0x0, data bytes 0x00..0x1F.
- Write 4 bytes 0xDEADBEEF to addr 0x24, then READ SIZE=2 from 0x24 -> data[31:0]=0xDEADBEEF, upper bits 0; bytes 0x20..0x23 of that word unchanged.
- Byte write 0xAA to addr 0x41 SIZE=0, then read SIZE=1 at 0x40 -> byte 1 = 0xAA, byte 0 retains prior value.
- Hold udev_resp_ready=0 after one READ -> udev_req_ready=0 and the response stays stable; raise ready -> response accepted and the next request accepted the same cycle.
- 8 back-to-back READs with resp_ready=1 -> 8 responses on consecutive cycles, in order, each 1 cycle after its request.
- Assert reset while resp_valid=1 -> resp_valid drops immediately (asynchronously); unknown opcode 0x55 -> accepted, no response.
